// File: rtl/base_arepeat.sv
// base_arepeat: valid/ready beat replicator emitting each accepted beat i_cnt times.
module base_arepeat #(
    parameter int width  = 8,
    parameter int cwidth = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_v,
    output logic              i_r,
    input  logic [width-1:0]  i_d,
    input  logic [cwidth-1:0] i_cnt,
    output logic              o_v,
    input  logic              o_r,
    output logic [width-1:0]  o_d,
    output logic [cwidth-1:0] o_idx,
    output logic              o_last
);
    typedef enum logic {idle, run} state_t;
    state_t            state;
    logic [width-1:0]  data;
    logic [cwidth-1:0] rem;
    logic [cwidth-1:0] idx;
    logic              acc;
    logic              xfer;
    assign o_v    = state == run;
    assign o_d    = data;
    assign o_idx  = idx;
    assign o_last = o_v && rem == cwidth'(1);
    // handing off on the final copy keeps back-to-back bursts bubble-free
    assign i_r    = !reset && (!o_v || (o_r && o_last));
    assign acc    = i_v && i_r;
    assign xfer   = o_v && o_r;
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= idle;
            data  <= '0;
            rem   <= '0;
            idx   <= '0;
        end else if (acc) begin
            if (i_cnt != '0) begin
                state <= run;
                data  <= i_d;
                rem   <= i_cnt;
                idx   <= '0;
            end else begin
                state <= idle;
            end
        end else if (xfer) begin
            rem <= rem - 1'b1;
            idx <= idx + 1'b1;
            if (o_last) state <= idle;
        end
    end
endmodule

// File: tb/tb_base_arepeat.sv
// tb_base_arepeat: directed and randomized checks of base_arepeat against a burst-level model.
module tb_base_arepeat;
    logic       clk = 0;
    logic       reset = 1;
    logic       i_v = 0;
    logic       i_r;
    logic [7:0] i_d = 0;
    logic [3:0] i_cnt = 0;
    logic       o_v;
    logic       o_r = 1;
    logic [7:0] o_d;
    logic [3:0] o_idx;
    logic       o_last;
    int errors = 0;
    int checks = 0;
    bit         have = 0;
    bit         fresh = 1;
    logic [7:0] m_d = 0;
    int         m_cnt = 0;
    int         m_k = 0;

    base_arepeat #(.width(8), .cwidth(4)) dut (
        .clk(clk), .reset(reset), .i_v(i_v), .i_r(i_r), .i_d(i_d), .i_cnt(i_cnt),
        .o_v(o_v), .o_r(o_r), .o_d(o_d), .o_idx(o_idx), .o_last(o_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model holds the current burst (data, count, copies already delivered).
    task automatic step();
        bit exp_ir, last, acc, xf;
        @(negedge clk);
        last   = have && (m_k == m_cnt - 1);
        exp_ir = !reset && (!have || (o_r && last));
        chk("i_r", i_r, exp_ir);
        chk("o_v", o_v, have);
        chk("o_last", o_last, last);
        if (have) begin
            chk("o_d", o_d, m_d);
            chk("o_idx", o_idx, m_k);
        end else if (fresh) begin
            chk("o_d_rst", o_d, 0);
            chk("o_idx_rst", o_idx, 0);
        end
        acc = i_v && exp_ir;
        xf  = have && o_r;
        @(posedge clk);
        if (reset) begin
            have  = 0;
            fresh = 1;
        end else begin
            if (xf) begin
                m_k++;
                if (m_k == m_cnt) have = 0;
            end
            if (acc && i_cnt != 0) begin
                have  = 1;
                fresh = 0;
                m_d   = i_d;
                m_cnt = i_cnt;
                m_k   = 0;
            end
        end
        #1;
    endtask

    initial begin
        #1;
        repeat (2) step();
        reset = 0;
        step();
        // single burst
        i_v = 1; i_d = 8'hA5; i_cnt = 3; o_r = 1;
        step();
        i_v = 0;
        repeat (4) step();
        // zero-count discard then single copy
        i_v = 1; i_d = 8'h11; i_cnt = 0;
        step();
        i_d = 8'h22; i_cnt = 1;
        step();
        i_v = 0;
        repeat (3) step();
        // back-to-back handoff on the final copy
        i_v = 1; i_d = 8'h01; i_cnt = 2;
        step();
        i_d = 8'h02; i_cnt = 1;
        repeat (2) step();
        i_v = 0;
        repeat (3) step();
        // backpressure
        i_v = 1; i_d = 8'h5A; i_cnt = 2; o_r = 1;
        step();
        i_v = 0; o_r = 0;
        repeat (4) step();
        o_r = 1;
        repeat (3) step();
        // max count
        i_v = 1; i_d = 8'hC3; i_cnt = 15;
        step();
        i_v = 0;
        repeat (16) step();
        // mid-burst reset
        i_v = 1; i_d = 8'h3C; i_cnt = 15;
        step();
        i_v = 0;
        repeat (5) step();
        reset = 1;
        step();
        reset = 0;
        repeat (4) step();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            i_v   = ($urandom % 4) != 0;
            i_d   = 8'($urandom);
            case ($urandom % 4)
                0:       i_cnt = 0;
                1:       i_cnt = 15;
                default: i_cnt = 4'($urandom_range(1, 4));
            endcase
            o_r   = ($urandom % 4) != 0;
            reset = ($urandom % 150) == 0;
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
